// File: rtl/matmul_bus_master_module_if.sv
// Host request/response and register-file bus signals of the matmul bus master.
// The master modport is the bus initiator; the slave modport is the host plus register file.
interface matmul_bus_master_module_if #(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = 2
);
  // Host request port
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [BUS_WIDTH-1:0]  req_data_i;
  logic [MAX_DIM-1:0]    req_strb_i;

  // Host response port
  logic                  rsp_valid_o;
  logic [BUS_WIDTH-1:0]  rsp_data_o;
  logic                  rsp_error_o;

  // Register-file bus
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [MAX_DIM-1:0]    pstrb_o;
  logic [BUS_WIDTH-1:0]  prdata_i;
  logic                  pready_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i, req_strb_i,
    output req_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_error_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_data_i, req_strb_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_error_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i
  );
endinterface

// File: rtl/matmul_bus_master_module.sv
// Bus initiator for the matmul register file: queues host requests in a FIFO and
// runs each as a setup/access transfer, screening illegal addresses and bounding stalls.
module matmul_bus_master_module #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  matmul_bus_master_module_if.master bus_if,
  output logic busy_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WAIT_W  = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  data;
    logic [MAX_DIM-1:0]    strb;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_e;

  // Register map screen on the low five address bits.
  function automatic logic addr_legal(input logic is_write, input logic [4:0] reg_sel);
    logic legal;
    case (reg_sel)
      5'b00000, 5'b00100, 5'b01100: legal = 1'b1;
      5'b01000, 5'b10000:           legal = !is_write;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

  req_t                  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  state_e                state_q;
  logic [WAIT_W-1:0]     wait_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [BUS_WIDTH-1:0]  pwdata_q;
  logic [MAX_DIM-1:0]    pstrb_q;
  logic                  rsp_valid_q, rsp_error_q;
  logic [BUS_WIDTH-1:0]  rsp_data_q;

  logic                  req_ready;
  logic                  push, pop;
  logic                  pop_state;
  logic                  head_legal;
  logic                  timeout_hit;
  req_t                  head;
  req_t                  incoming;

  assign req_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign push        = bus_if.req_valid_i && req_ready;
  assign pop_state   = (state_q == S_IDLE) || (state_q == S_RESP) || (state_q == S_ERR);
  assign pop         = pop_state && (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign head_legal  = addr_legal(head.write, head.addr[4:0]);
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

  assign incoming.write = bus_if.req_write_i;
  assign incoming.addr  = bus_if.req_addr_i;
  assign incoming.data  = bus_if.req_data_i;
  assign incoming.strb  = bus_if.req_strb_i;

  // Storage carries no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= incoming;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      case (state_q)
        S_IDLE, S_RESP, S_ERR: begin
          state_q   <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
          paddr_q   <= '0;
          pwdata_q  <= '0;
          pstrb_q   <= '0;
          if (pop) begin
            if (head_legal) begin
              state_q  <= S_SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= head.write;
              paddr_q  <= head.addr;
              pwdata_q <= head.write ? head.data : '0;
              pstrb_q  <= head.write ? head.strb : '0;
            end else begin
              // Illegal accesses never reach the bus.
              state_q     <= S_ERR;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        S_ACCESS: begin
          if (bus_if.pready_i || timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b1;
            // A completing transfer wins over a timeout on the same cycle.
            if (bus_if.pready_i) begin
              state_q <= S_RESP;
              if (!pwrite_q) rsp_data_q <= bus_if.prdata_i;
            end else begin
              state_q     <= S_ERR;
              rsp_error_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.req_ready_o = req_ready;
  assign bus_if.rsp_valid_o = rsp_valid_q;
  assign bus_if.rsp_error_o = rsp_error_q;
  assign bus_if.rsp_data_o  = rsp_data_q;
  assign bus_if.psel_o      = psel_q;
  assign bus_if.penable_o   = penable_q;
  assign bus_if.pwrite_o    = pwrite_q;
  assign bus_if.paddr_o     = paddr_q;
  assign bus_if.pwdata_o    = pwdata_q;
  assign bus_if.pstrb_o     = pstrb_q;
  assign busy_o             = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_matmul_bus_master_module.sv
// Bench for matmul_bus_master_module: directed and random requests checked against a
// transaction-level model of the register-file screen, timeout rule and response order.
module tb_matmul_bus_master_module;
  localparam int DW = 32, BW = 64, AW = 32, FD = 4, TO = 16, MD = BW / DW;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  matmul_bus_master_module_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD)) ifc ();

  matmul_bus_master_module #(
    .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus_if(ifc),
    .busy_o(busy)
  );

  typedef struct {logic [63:0] data; logic err; int push_cyc; int lat;} rsp_t;
  typedef struct {logic w; logic [31:0] a; logic [63:0] d; logic [1:0] s;} bus_t;

  rsp_t exp_q[$];
  bus_t bus_q[$];
  int   stall_q[$];
  int   n_checks = 0, n_pass = 0, cyc = 0, nrsp = 0;
  int   cur_stall = 0, acc_cnt = 0;
  bus_t rb;
  rsp_t er;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Register file read contents as seen by the bench.
  function automatic logic [63:0] rd_val(input logic [31:0] a);
    if (a == 32'h4) return 64'h0003_0002_0001_0000;
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  function automatic logic reg_legal(input logic w, input logic [31:0] a);
    logic [4:0] s;
    s = a[4:0];
    if (s == 5'h00 || s == 5'h04 || s == 5'h0C) return 1'b1;
    if (s == 5'h08 || s == 5'h10) return !w;
    return 1'b0;
  endfunction

  // One push attempt; the model records the request only when it is accepted.
  task automatic push(input logic w, input logic [31:0] a, input logic [63:0] d,
                      input logic [1:0] s, input int stall, input int lat, output logic acc);
    rsp_t r;
    bus_t b;
    logic ok;
    @(negedge clk);
    ifc.req_valid_i = 1'b1;
    ifc.req_write_i = w;
    ifc.req_addr_i  = a;
    ifc.req_data_i  = d;
    ifc.req_strb_i  = s;
    acc = ifc.req_ready_o;
    @(posedge clk);
    #1;
    ifc.req_valid_i = 1'b0;
    if (acc) begin
      ok = reg_legal(w, a);
      if (ok) begin
        b.w = w; b.a = a; b.d = w ? d : 64'h0; b.s = w ? s : 2'b00;
        bus_q.push_back(b);
        stall_q.push_back(stall);
      end
      r.err      = !ok || (stall >= TO);
      r.data     = (r.err || w) ? 64'h0 : rd_val(a);
      r.push_cyc = cyc;
      r.lat      = lat;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && (busy || exp_q.size() != 0); i++) @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_drained", exp_q.size(), 0);
  endtask

  task automatic wait_access();
    for (int i = 0; i < 20 && !(ifc.psel_o && ifc.penable_o); i++) @(negedge clk);
    chk("reach_access", ifc.penable_o, 1);
  endtask

  // Register-file responder: stalls each transfer by its planned count.
  always @(negedge clk) begin
    if (!rst_ni) begin
      ifc.pready_i = 1'b0;
      acc_cnt = 0;
    end else begin
      ifc.pready_i = 1'b0;
      ifc.prdata_i = {$urandom, $urandom};
      if (ifc.psel_o && !ifc.penable_o) begin
        if (bus_q.size() == 0) chk("unexpected_bus", ifc.psel_o, 0);
        else begin
          rb = bus_q.pop_front();
          chk("bus_pwrite", ifc.pwrite_o, rb.w);
          chk("bus_paddr", ifc.paddr_o, rb.a);
          chk("bus_pwdata", ifc.pwdata_o, rb.d);
          chk("bus_pstrb", ifc.pstrb_o, rb.s);
        end
        cur_stall = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
        acc_cnt = 0;
      end else if (ifc.psel_o && ifc.penable_o) begin
        if (acc_cnt == cur_stall) begin
          ifc.pready_i = 1'b1;
          ifc.prdata_i = rd_val(ifc.paddr_o);
        end
        acc_cnt++;
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_ni && ifc.rsp_valid_o) begin
      nrsp++;
      $display("rsp %0d: err=%0d data=%h cyc=%0d", nrsp, ifc.rsp_error_o, ifc.rsp_data_o, cyc);
      if (exp_q.size() == 0) chk("unexpected_rsp", ifc.rsp_valid_o, 0);
      else begin
        er = exp_q.pop_front();
        chk("rsp_error", ifc.rsp_error_o, er.err);
        chk("rsp_data", ifc.rsp_data_o, er.data);
        if (er.lat >= 0) chk("rsp_latency", cyc - er.push_cyc, er.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n0, st;
    logic [31:0] a;
    logic [4:0] sels [8];
    sels = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h03};
    ifc.req_valid_i = 0; ifc.req_write_i = 0; ifc.req_addr_i = '0;
    ifc.req_data_i = '0; ifc.req_strb_i = '0; ifc.prdata_i = '0; ifc.pready_i = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", ifc.psel_o, 0);
    chk("rst_penable", ifc.penable_o, 0);
    chk("rst_paddr", ifc.paddr_o, 0);
    chk("rst_rsp_valid", ifc.rsp_valid_o, 0);
    chk("rst_rsp_error", ifc.rsp_error_o, 0);
    chk("rst_rsp_data", ifc.rsp_data_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ifc.req_ready_o, 1);
    @(negedge clk);
    rst_ni = 1'b1;

    // Write CONTROL at minimum latency.
    push(1'b1, 32'h0, 64'h25, 2'b11, 0, 3, acc);
    chk("t1_accept", acc, 1);
    @(posedge clk); #1;
    chk("t1_setup_psel", ifc.psel_o, 1);
    chk("t1_setup_penable", ifc.penable_o, 0);
    @(posedge clk); #1;
    chk("t1_access_penable", ifc.penable_o, 1);
    chk("t1_access_pwrite", ifc.pwrite_o, 1);
    wait_idle();

    // Read OPERAND_A with two wait cycles.
    push(1'b0, 32'h4, 64'h0, 2'b00, 2, 5, acc);
    wait_idle();

    // FIFO fills behind a stalled transfer; fifth push is refused.
    n0 = nrsp;
    push(1'b0, 32'h0, 64'h0, 2'b00, 12, -1, acc);
    wait_access();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, {$urandom_range(0, 255), 5'h04}, {$urandom, $urandom}, 2'b01, 0, -1, acc);
      chk("full_accept", acc, (i < 4));
    end
    wait_idle();
    chk("full_rsp_count", nrsp - n0, 5);

    // Illegal accesses: write to FLAGS, read of an unmapped register.
    n0 = nrsp;
    push(1'b1, 32'h8, 64'hDEAD_BEEF, 2'b11, 0, -1, acc);
    repeat (2) @(negedge clk);
    #1;
    chk("illegal1_rsp", nrsp - n0, 1);
    push(1'b0, 32'h14, 64'h0, 2'b00, 0, -1, acc);
    repeat (2) @(negedge clk);
    #1;
    chk("illegal2_rsp", nrsp - n0, 2);
    wait_idle();

    // Timeout on SP, queued request proceeds; completion on the last allowed cycle wins.
    push(1'b0, 32'h30, 64'h0, 2'b00, 100, 18, acc);
    push(1'b0, 32'h0C, 64'h0, 2'b00, 1, -1, acc);
    wait_idle();
    push(1'b0, 32'h10, 64'h0, 2'b00, TO - 1, 18, acc);
    wait_idle();
    push(1'b0, 32'h10, 64'h0, 2'b00, TO, 18, acc);
    wait_idle();

    // Random mix of legal/illegal requests and stalls.
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      a[4:0] = sels[$urandom_range(0, 7)];
      st = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 3);
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++)
        push($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             st, -1, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Reset during ACCESS with two requests queued.
    push(1'b0, 32'h0, 64'h0, 2'b00, 12, -1, acc);
    wait_access();
    push(1'b0, 32'h4, 64'h0, 2'b00, 0, -1, acc);
    push(1'b1, 32'h0, 64'h1, 2'b11, 0, -1, acc);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_psel", ifc.psel_o, 0);
    chk("mid_rst_penable", ifc.penable_o, 0);
    chk("mid_rst_paddr", ifc.paddr_o, 0);
    chk("mid_rst_rsp_valid", ifc.rsp_valid_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ifc.req_ready_o, 1);
    exp_q.delete();
    bus_q.delete();
    stall_q.delete();
    n0 = nrsp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_no_rsp", nrsp - n0, 0);
    chk("post_rst_ready", ifc.req_ready_o, 1);
    chk("post_rst_busy", busy, 0);

    push(1'b0, 32'h4, 64'h0, 2'b00, 0, 3, acc);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
